// File: rtl/fetch_pkg.sv
// Shared types and constants for the SCC instruction-fetch sequencer.
package fetch_pkg;

    localparam logic [7:0]  OP_B        = 8'hA0;
    localparam logic [7:0]  OP_NOP      = 8'hA8;
    localparam int unsigned FETCH_DEPTH = 2;
    localparam int unsigned ENTRY_PC_W  = 32;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO (head always in slot 0) with push, pop and flush;
// a push and a pop may coincide when full.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    input  logic        pop,
    input  logic        flush,
    output logic [31:0] head_pc,
    output logic [31:0] head_instr,
    output logic [1:0]  count,
    output logic        empty,
    output logic        full
);

    fetch_entry_t slots [FETCH_DEPTH];
    fetch_entry_t in_entry;
    logic         pop_ok;
    logic         push_ok;

    assign in_entry   = '{pc: push_pc, instr: push_instr};
    assign empty      = (count == 2'd0);
    assign full       = (count == 2'(FETCH_DEPTH));
    assign pop_ok     = pop & ~empty;
    assign push_ok    = push & (~full | pop_ok);
    assign head_pc    = slots[0].pc;
    assign head_instr = slots[0].instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
                slots[i] <= '0;
            end
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b11: begin
                    // Head leaves; the newcomer lands behind whatever remains.
                    if (count == 2'd1) begin
                        slots[0] <= in_entry;
                    end else begin
                        slots[0] <= slots[1];
                        slots[1] <= in_entry;
                    end
                end
                2'b10: begin
                    if (empty) slots[0] <= in_entry;
                    else       slots[1] <= in_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slots[0] <= slots[1];
                    count    <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC generation, one-cycle memory latency tracking,
// redirect squashing and decode handshake. Optional: FETCH_PREDECODE_BRANCH_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              idle
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] tag;
    logic              infl;
    logic              issue;
    logic              keep;
    logic              xfer;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              buf_empty;
    logic              buf_full;
    logic [31:0]       head_pc;

    assign imem_addr = pc;
    assign xfer      = ins_valid & ins_ready;
    // A return coinciding with a redirect belongs to the old stream.
    assign keep      = infl & ~redirect_valid;
    assign occupancy = {1'b0, count} + {2'b00, infl} - {2'b00, xfer};

`ifdef FETCH_PREDECODE_BRANCH_EN
    assign br_taken  = keep & (imem_rdata[31:24] == OP_B);
    assign br_target = tag + {{(ADDR_W-16){imem_rdata[15]}}, imem_rdata[15:0]};
`else
    assign br_taken  = 1'b0;
    assign br_target = '0;
`endif

    assign issue = (state == RUN) & ~halt & ~redirect_valid & ~br_taken
                 & (occupancy < 3'd2);

    always_comb begin
        pc_next = pc;
        if (redirect_valid)  pc_next = redirect_pc;
        else if (br_taken)   pc_next = br_target;
        else if (issue)      pc_next = pc + ADDR_W'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt)  state_next = HALTED;
            HALTED:  if (!halt) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            tag   <= '0;
            infl  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            infl  <= issue;
            if (issue) tag <= pc;
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (keep),
        .push_pc    (32'(tag)),
        .push_instr (imem_rdata),
        .pop        (xfer),
        .flush      (redirect_valid),
        .head_pc    (head_pc),
        .head_instr (ins_data),
        .count      (count),
        .empty      (buf_empty),
        .full       (buf_full)
    );

    assign ins_valid = ~buf_empty;
    assign ins_pc    = ADDR_W'(head_pc);
    assign idle      = (state == HALTED) & ~infl & buf_empty;

    logic unused;
    assign unused = buf_full;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a synchronous one-cycle-latency memory model.
module tb_fetch_sequencer;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = '0;
    logic              ins_valid;
    logic              ins_ready = 1'b1;
    logic [31:0]       ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halt = 1'b0;
    logic              idle;

    logic [31:0] mem [0:63];
    int vectors     = 0;
    int miscompares = 0;

    fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr[5:0]];

    task automatic init_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h1100_0000 | 32'(i);
        mem[0] = 32'h2200_0005;
        mem[1] = 32'h2440_0003;
        mem[2] = 32'hA800_0000;
    endtask

    // Leaves the bench at the first sample point after reset release (cycle 0).
    task automatic do_reset();
        rst = 1'b1;
        ins_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_and_stream();
        logic [31:0] exp_data [0:5];
        exp_data[0] = 32'h2200_0005; exp_data[1] = 32'h2440_0003;
        exp_data[2] = 32'hA800_0000; exp_data[3] = 32'h1100_0003;
        exp_data[4] = 32'h1100_0004; exp_data[5] = 32'h1100_0005;
        init_mem();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ins_valid !== 1'b0 || imem_addr !== 32'h0 || ins_data !== 32'h0 ||
            ins_pc !== 32'h0 || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: valid=%b addr=%h data=%h pc=%h idle=%b want 0 0 0 0 0",
                     ins_valid, imem_addr, ins_data, ins_pc, idle);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ins_valid !== 1'b0 || imem_addr !== 32'h1) begin
            miscompares++;
            $display("FAIL cycle1: valid=%b addr=%h want 0 00000001", ins_valid, imem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== 32'(i) || ins_data !== exp_data[i]) begin
                miscompares++;
                $display("FAIL stream[%0d]: valid=%b pc=%h data=%h want 1 %h %h",
                         i, ins_valid, ins_pc, ins_data, 32'(i), exp_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        init_mem();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        ins_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== 32'h1 || imem_addr !== 32'h3) begin
                miscompares++;
                $display("FAIL stall[%0d]: valid=%b pc=%h addr=%h want 1 00000001 00000003",
                         i, ins_valid, ins_pc, imem_addr);
            end
        end
        ins_ready = 1'b1;
        for (int i = 2; i < 7; i++) begin
            @(negedge clk);
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== 32'(i) || ins_data !== mem[i]) begin
                miscompares++;
                $display("FAIL resume[%0d]: valid=%b pc=%h data=%h want 1 %h %h",
                         i, ins_valid, ins_pc, ins_data, 32'(i), mem[i]);
            end
        end
    endtask

    task automatic test_redirect();
        init_mem();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        ins_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h1 || imem_addr !== 32'h3) begin
            miscompares++;
            $display("FAIL redir_pre: valid=%b pc=%h addr=%h want 1 00000001 00000003",
                     ins_valid, ins_pc, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        ins_ready = 1'b1;
        vectors++;
        if (ins_valid !== 1'b0 || imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL redir_n1: valid=%b addr=%h want 0 00000010", ins_valid, imem_addr);
        end
        @(negedge clk);
        vectors++;
        if (ins_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_n2: valid=%b want 0", ins_valid);
        end
        for (int i = 16; i < 18; i++) begin
            @(negedge clk);
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== 32'(i) || ins_data !== mem[i]) begin
                miscompares++;
                $display("FAIL redir_stream[%0d]: valid=%b pc=%h data=%h want 1 %h %h",
                         i, ins_valid, ins_pc, ins_data, 32'(i), mem[i]);
            end
        end
    endtask

    task automatic test_halt();
        init_mem();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (imem_addr !== 32'h2) begin
            miscompares++;
            $display("FAIL halt_addr: addr=%h want 00000002", imem_addr);
        end
        halt = 1'b1;
        @(negedge clk);
        vectors++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h1 || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_drain: valid=%b pc=%h idle=%b want 1 00000001 0",
                     ins_valid, ins_pc, idle);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (ins_valid !== 1'b0 || idle !== 1'b1 || imem_addr !== 32'h2) begin
                miscompares++;
                $display("FAIL halt_idle[%0d]: valid=%b idle=%b addr=%h want 0 1 00000002",
                         i, ins_valid, idle, imem_addr);
            end
        end
        halt = 1'b0;
        @(negedge clk);
        vectors++;
        if (idle !== 1'b0 || imem_addr !== 32'h2) begin
            miscompares++;
            $display("FAIL unhalt: idle=%b addr=%h want 0 00000002", idle, imem_addr);
        end
        @(negedge clk);
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== 32'(i)) begin
                miscompares++;
                $display("FAIL halt_resume[%0d]: valid=%b pc=%h want 1 %h",
                         i, ins_valid, ins_pc, 32'(i));
            end
        end
    endtask

    task automatic test_predecode_branch();
        int exp_pc [0:6];
        int got;
`ifdef FETCH_PREDECODE_BRANCH_EN
        exp_pc = '{0, 1, 2, 3, 0, 1, 2};
`else
        exp_pc = '{0, 1, 2, 3, 4, 5, 6};
`endif
        init_mem();
        mem[3] = 32'hA000_FFFD;
        do_reset();
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ins_valid === 1'b1 && got < 7) begin
                vectors++;
                if (ins_pc !== 32'(exp_pc[got]) || ins_data !== mem[exp_pc[got]]) begin
                    miscompares++;
                    $display("FAIL branch_seq[%0d]: pc=%h data=%h want %h %h",
                             got, ins_pc, ins_data, 32'(exp_pc[got]), mem[exp_pc[got]]);
                end
                got++;
            end
        end
        vectors++;
        if (got != 7) begin
            miscompares++;
            $display("FAIL branch_count: delivered=%0d want 7", got);
        end
    endtask

    task automatic test_reset_mid_stream();
        init_mem();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h1) begin
            miscompares++;
            $display("FAIL mid_pre: valid=%b pc=%h want 1 00000001", ins_valid, ins_pc);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (ins_valid !== 1'b0 || imem_addr !== 32'h0 || ins_pc !== 32'h0 ||
            ins_data !== 32'h0 || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b addr=%h pc=%h data=%h idle=%b want 0 0 0 0 0",
                     ins_valid, imem_addr, ins_pc, ins_data, idle);
        end
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== 32'(i) || ins_data !== mem[i]) begin
                miscompares++;
                $display("FAIL restart[%0d]: valid=%b pc=%h data=%h want 1 %h %h",
                         i, ins_valid, ins_pc, ins_data, 32'(i), mem[i]);
            end
        end
    endtask

    initial begin
        test_reset_and_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_predecode_branch();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
